// File: rtl/rr_arbiter32_pkg.sv
// Shared constants, state encoding and helpers for the 32-way round-robin arbiter.
package rr_arbiter32_pkg;

    localparam int N_REQ = 32;
    localparam int IDX_W = 5;
    localparam int CNT_W = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Saturating increment: the hold counter must never wrap back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] res;
        res = (cnt == {CNT_W{1'b1}}) ? cnt : (cnt + CNT_W'(1));
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter32_pick.sv
// Combinational rotate-priority picker: first set request at or above ptr, wrapping.
module rr_pick
    import rr_arbiter32_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] pick,
    output logic [IDX_W-1:0] pick_idx,
    output logic             any
);

    logic [2*N_REQ-1:0] rot_wide_s;
    logic [N_REQ-1:0]   rot_s;
    logic [IDX_W-1:0]   first_idx_s;
    logic [N_REQ-1:0]   first_oh_s;
    logic [2*N_REQ-1:0] back_wide_s;

    // Rotate right so ptr lands at bit 0, then take the lowest set bit.
    always_comb begin
        rot_wide_s  = {req, req} >> ptr;
        rot_s       = rot_wide_s[N_REQ-1:0];
        first_idx_s = {IDX_W{1'b0}};
        for (int i = N_REQ - 1; i >= 0; i--) begin
            first_idx_s = rot_s[i] ? IDX_W'(i) : first_idx_s;
        end
        any        = |rot_s;
        first_oh_s = any ? (N_REQ'(1) << first_idx_s) : {N_REQ{1'b0}};
    end

    // Rotate the one-hot result back into requester numbering and rebase the index.
    always_comb begin
        back_wide_s = {first_oh_s, first_oh_s} << ptr;
        pick        = back_wide_s[2*N_REQ-1:N_REQ];
        pick_idx    = first_idx_s + ptr;
    end

endmodule

// File: rtl/rr_arbiter32.sv
// 32-requester round-robin arbiter with grant hold, owner release and hold timeout.
module rr_arbiter32
    import rr_arbiter32_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] HOLD_LAST_C = CNT_W'(MAX_HOLD - 1);

    state_e           state_r,    state_nxt_s;
    logic [N_REQ-1:0] gnt_r,      gnt_nxt_s;
    logic [IDX_W-1:0] gnt_idx_r,  gnt_idx_nxt_s;
    logic             valid_r,    valid_nxt_s;
    logic             timeout_r,  timeout_nxt_s;
    logic [IDX_W-1:0] ptr_r,      ptr_nxt_s;
    logic [CNT_W-1:0] hold_cnt_r, hold_cnt_nxt_s;

    logic [N_REQ-1:0] pick_s;
    logic [IDX_W-1:0] pick_idx_s;
    logic             any_s;
    logic             owner_req_s;
    logic             hold_hit_s;
    logic             release_s;

    rr_pick u_pick (
        .req      (req),
        .ptr      (ptr_r),
        .pick     (pick_s),
        .pick_idx (pick_idx_s),
        .any      (any_s)
    );

    // Release causes for the current owner; timeout only when the counter alone forces it.
    always_comb begin
        owner_req_s = req[gnt_idx_r];
        hold_hit_s  = (hold_cnt_r == HOLD_LAST_C);
        release_s   = done || !owner_req_s || hold_hit_s;
    end

    // Next-state and next-output logic for the IDLE/BUSY grant machine.
    always_comb begin
        state_nxt_s    = state_r;
        gnt_nxt_s      = gnt_r;
        gnt_idx_nxt_s  = gnt_idx_r;
        valid_nxt_s    = valid_r;
        timeout_nxt_s  = 1'b0;
        ptr_nxt_s      = ptr_r;
        hold_cnt_nxt_s = hold_cnt_r;
        case (state_r)
            IDLE: begin
                if (any_s) begin
                    state_nxt_s    = BUSY;
                    gnt_nxt_s      = pick_s;
                    gnt_idx_nxt_s  = pick_idx_s;
                    valid_nxt_s    = 1'b1;
                    ptr_nxt_s      = pick_idx_s + IDX_W'(1);
                    hold_cnt_nxt_s = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s    = IDLE;
                end
            end
            BUSY: begin
                if (release_s) begin
                    state_nxt_s   = IDLE;
                    gnt_nxt_s     = {N_REQ{1'b0}};
                    valid_nxt_s   = 1'b0;
                    timeout_nxt_s = hold_hit_s && !done && owner_req_s;
                end else begin
                    hold_cnt_nxt_s = sat_inc(hold_cnt_r);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                gnt_nxt_s   = {N_REQ{1'b0}};
                valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State, pointer, counter and output registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            gnt_r      <= {N_REQ{1'b0}};
            gnt_idx_r  <= {IDX_W{1'b0}};
            valid_r    <= 1'b0;
            timeout_r  <= 1'b0;
            ptr_r      <= {IDX_W{1'b0}};
            hold_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            gnt_r      <= gnt_nxt_s;
            gnt_idx_r  <= gnt_idx_nxt_s;
            valid_r    <= valid_nxt_s;
            timeout_r  <= timeout_nxt_s;
            ptr_r      <= ptr_nxt_s;
            hold_cnt_r <= hold_cnt_nxt_s;
        end
    end

    assign gnt       = gnt_r;
    assign gnt_idx   = gnt_idx_r;
    assign gnt_valid = valid_r;
    assign timeout   = timeout_r;

endmodule

// File: tb/tb_rr_arbiter32.sv
// Directed bench for rr_arbiter32 (MAX_HOLD=4); outputs sampled on the falling edge.
module tb_rr_arbiter32;

    logic        clk;
    logic        rst;
    logic [31:0] req;
    logic        done;
    logic [31:0] gnt;
    logic [4:0]  gnt_idx;
    logic        gnt_valid;
    logic        timeout;

    int pass_cnt;
    int fail_cnt;
    int total_cnt;

    rr_arbiter32 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=no finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_gnt, input logic [4:0] e_idx,
                             input logic e_valid, input logic e_to);
        check({tag, ".gnt"},       gnt,               e_gnt);
        check({tag, ".gnt_idx"},   {27'd0, gnt_idx},  {27'd0, e_idx});
        check({tag, ".gnt_valid"}, {31'd0, gnt_valid}, {31'd0, e_valid});
        check({tag, ".timeout"},   {31'd0, timeout},  {31'd0, e_to});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int exp_idx;
        pass_cnt  = 0;
        fail_cnt  = 0;
        total_cnt = 0;
        rst  = 1'b1;
        req  = 32'h0;
        done = 1'b0;
        @(negedge clk);
        tick();
        rst = 1'b0;
        check_all("reset", 32'h0, 5'd0, 1'b0, 1'b0);

        // Single request, done on the 3rd grant cycle.
        req = 32'h0000_0010;
        tick();
        check_all("single.c1", 32'h0000_0010, 5'd4, 1'b1, 1'b0);
        tick();
        check_all("single.c2", 32'h0000_0010, 5'd4, 1'b1, 1'b0);
        tick();
        check_all("single.c3", 32'h0000_0010, 5'd4, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        check_all("single.rel", 32'h0, 5'd4, 1'b0, 1'b0);
        done = 1'b0;
        req  = 32'h0;
        tick();
        check_all("single.idle", 32'h0, 5'd4, 1'b0, 1'b0);

        // Rotation between requesters 0 and 31 starting from ptr=0.
        do_reset();
        req = 32'h8000_0001;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_idx = (k % 2 == 0) ? 0 : 31;
            check_all("rot.grant", 32'h1 << exp_idx, 5'(exp_idx), 1'b1, 1'b0);
            done = 1'b1;
            tick();
            check_all("rot.rel", 32'h0, 5'(exp_idx), 1'b0, 1'b0);
            done = 1'b0;
        end
        req = 32'h0;
        tick();

        // Hold timeout: ptr=0 here, grant lasts 4 cycles, timeout during the idle cycle.
        req = 32'h0000_0100;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_all("to.hold", 32'h0000_0100, 5'd8, 1'b1, 1'b0);
        end
        tick();
        check_all("to.pulse", 32'h0, 5'd8, 1'b0, 1'b1);
        tick();
        check_all("to.regrant", 32'h0000_0100, 5'd8, 1'b1, 1'b0);
        req = 32'h0;
        tick();
        check_all("to.withdraw", 32'h0, 5'd8, 1'b0, 1'b0);

        // Withdraw: ptr=9, only requester 5 asks, then drops while 9 asks.
        req = 32'h0000_0020;
        tick();
        check_all("wd.grant5", 32'h0000_0020, 5'd5, 1'b1, 1'b0);
        req = 32'h0000_0200;
        tick();
        check_all("wd.rel", 32'h0, 5'd5, 1'b0, 1'b0);
        tick();
        check_all("wd.grant9", 32'h0000_0200, 5'd9, 1'b1, 1'b0);
        req = 32'h0;
        tick();

        // Fairness: everyone requests, done every cycle.
        do_reset();
        req  = 32'hFFFF_FFFF;
        done = 1'b1;
        for (int k = 0; k < 33; k++) begin
            tick();
            check_all("fair.grant", 32'h1 << (k % 32), 5'(k % 32), 1'b1, 1'b0);
            if (k < 32) begin
                tick();
                check("fair.idle", {31'd0, gnt_valid}, 32'd0);
            end
        end

        // Mid-grant reset: ptr=1, owner 0 withdraws, then requester 10 is granted.
        done = 1'b0;
        req  = 32'h0000_0400;
        tick();
        check("mr.rel", {31'd0, gnt_valid}, 32'd0);
        tick();
        check_all("mr.grant10", 32'h0000_0400, 5'd10, 1'b1, 1'b0);
        rst = 1'b1;
        req = 32'hFFFF_FFFF;
        tick();
        check_all("mr.reset", 32'h0, 5'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        check_all("mr.after", 32'h0000_0001, 5'd0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
